// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front-end pipeline stages.
package mips_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    localparam addr_t  RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam instr_t INSTR_NOP        = 32'h0000_0000;

    // HOLD means the skid entry is occupied and fetch is paused.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding register that catches a fetch return while decode stalls.
module if_skid_buf
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fill,
    input  logic               drain,
    input  logic               flush,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic [ADDR_W-1:0]  fill_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    always_ff @(posedge clk) begin
        if (rst || flush)
            valid <= 1'b0;
        else if (fill)
            valid <= 1'b1;
        else if (drain)
            valid <= 1'b0;
    end

    // Payload is only meaningful while valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            instr <= fill_instr;
            pc    <= fill_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, 1-cycle imem requests, skid-buffered valid/ready output.
// Optional macro IF_PERF_CNT_EN adds saturating transfer/stall performance counters.
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               inflight;
    logic               skid_valid;
    logic               skid_fill;
    logic               skid_drain;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    if_state_e          state;
    logic               out_free;
    logic               stall_hold;
    logic               load_out;
    logic [INSTR_W-1:0] load_instr;
    logic [ADDR_W-1:0]  load_pc;
    logic               unused_ok;

    assign unused_ok  = ^redirect_pc[1:0];
    assign state      = skid_valid ? HOLD : RUN;
    assign out_free   = !id_valid || id_ready;
    assign stall_hold = id_valid && !id_ready;

    // A return that would find both the output and skid occupied is never requested.
    assign imem_req   = !rst && !redirect_valid && (state == RUN) && !(stall_hold && inflight);
    assign imem_addr  = pc;

    assign skid_fill  = !redirect_valid && inflight && !out_free;
    assign skid_drain = !redirect_valid && skid_valid && out_free;

    if_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .fill       (skid_fill),
        .drain      (skid_drain),
        .flush      (redirect_valid),
        .fill_instr (imem_rdata),
        .fill_pc    (req_pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        load_out   = 1'b0;
        load_instr = skid_instr;
        load_pc    = skid_pc;
        if (skid_drain) begin
            load_out = 1'b1;
        end else if (!redirect_valid && inflight && out_free) begin
            load_out   = 1'b1;
            load_instr = imem_rdata;
            load_pc    = req_pc;
        end
    end

    // Request stage: PC and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            if (imem_req)
                pc <= pc + ADDR_W'(4);
            inflight <= imem_req;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req)
            req_pc <= pc;
    end

    // Return stage: output register presented to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_instr    <= INSTR_W'(INSTR_NOP);
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (load_out) begin
            id_valid    <= 1'b1;
            id_instr    <= load_instr;
            id_pc       <= load_pc;
            id_pc_plus4 <= load_pc + ADDR_W'(4);
        end else if (out_free) begin
            id_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_valid && id_ready && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_hold && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected fetch streams queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_if_stage;
    import mips_pkg::*;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int stalls   = 0;

    addr_t exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr, prev_pc, prev_pc4;
    logic [31:0] e;

    always #5 clk = ~clk;

    if_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    // Synchronous memory: data for the requested address one cycle later, noise otherwise.
    always @(posedge clk)
        imem_rdata <= imem_req ? word_of(imem_addr) : $urandom;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_xfers(input int n, input int budget, input string name);
        int start;
        int cyc;
        start = xfers;
        cyc   = 0;
        while ((xfers - start < n) && (cyc < budget)) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(name, 32'(xfers - start >= n), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        chk("redir_req_low", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream({tgt[31:2], 2'b00}, 1024);
        @(negedge clk);
        chk("redir_valid_clr", 32'(id_valid), 32'd0);
        chk("redir_addr", imem_addr, {tgt[31:2], 2'b00});
        chk("redir_req_next", 32'(imem_req), 32'd1);
    endtask

    // Monitor: every decode transfer pops the next expected fetch.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && id_valid) begin
                chk("hold_instr", id_instr, prev_instr);
                chk("hold_pc", id_pc, prev_pc);
                chk("hold_pc4", id_pc_plus4, prev_pc4);
            end
            if (id_valid && id_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_pc=%h expected=none", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", id_pc, e);
                    chk("sb_pc4", id_pc_plus4, e + 32'd4);
                    chk("sb_instr", id_instr, word_of(e));
                end
            end
            if (id_valid && !id_ready)
                stalls++;
        end
        prev_stall = !rst && id_valid && !id_ready;
        prev_instr = id_instr;
        prev_pc    = id_pc;
        prev_pc4   = id_pc_plus4;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int xr;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'd0);
        chk("rst_addr", imem_addr, RPC);

        // Reset release: first request immediately, first valid two cycles later.
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        push_stream(RPC, 1024);
        @(negedge clk);
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("boot_addr0", imem_addr, RPC);
        chk("boot_valid0", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("boot_addr1", imem_addr, RPC + 32'd4);
        chk("boot_valid1", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("boot_valid2", 32'(id_valid), 32'd1);
        chk("boot_addr2", imem_addr, RPC + 32'd8);
        @(posedge clk); #1;
        x0 = xfers;
        repeat (8) @(posedge clk);
        #1;
        chk("throughput", 32'(xfers - x0), 32'd8);

        // Three-cycle decode stall mid-stream.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        @(posedge clk); #1;
        id_ready = 1'b1;
        wait_xfers(10, 40, "stall_resume");

        // Redirect while the skid entry is full.
        id_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_redirect(32'h0000_1003);
        @(posedge clk); #1;
        id_ready = 1'b1;
        wait_xfers(6, 30, "redir_resume");

        // Address wrap at the top of the space.
        do_redirect(32'hFFFF_FFF8);
        @(negedge clk);
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr2", imem_addr, 32'h0000_0000);
        wait_xfers(3, 20, "wrap_xfers");

        // Reset with the skid full.
        @(posedge clk); #1;
        id_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_stream(RPC, 1024);
        @(negedge clk);
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_instr", id_instr, 32'd0);
        chk("mrst_pc", id_pc, 32'd0);
        chk("mrst_pc4", id_pc_plus4, 32'd0);
        chk("mrst_addr", imem_addr, RPC);
        chk("mrst_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        id_ready = 1'b1;
        wait_xfers(5, 30, "mrst_resume");

        // Randomized ready pattern with occasional redirects.
        xr = xfers;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0)
                do_redirect($urandom);
        end
        @(posedge clk); #1;
        id_ready = 1'b1;
        chk("random_progress", 32'(xfers - xr > 150), 32'd1);
        wait_xfers(4, 20, "random_tail");

`ifdef IF_PERF_CNT_EN
        // Performance counters: exactly 10 transfers then 4 stall cycles.
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_rst_stall", perf_stall_cnt, 32'd0);
        rst = 1'b0;
        push_stream(RPC, 1024);
        begin
            int base;
            int cyc;
            base = xfers;
            cyc  = 0;
            while ((xfers - base < 10) && (cyc < 50)) begin
                @(posedge clk); #1;
                cyc++;
            end
            id_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk("perf_fetch", perf_fetch_cnt, 32'd10);
            chk("perf_stall", perf_stall_cnt, 32'd4);
            id_ready = 1'b1;
        end
`endif

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
